// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
//
// Contents:
//   fseq_state_t      fetch FSM states (BOOT, REQ, WAIT, HOLD)
//   DEFAULT_RESET_PC  default first fetch address after reset
//   PC_STEP           byte distance between sequential RV32 instructions
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fseq_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          PC_STEP          = 4;

endpackage

// File: rtl/fseq_pc_gen.sv
// rtl/fseq_pc_gen.sv - program counter register with +4 increment and redirect load
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous reset, active-low (pc returns to RESET_PC)
//   loadEn   in   take loadPc this cycle (has priority over incEn)
//   loadPc   in   redirect target; low two bits are discarded
//   incEn    in   advance pc by PC_STEP this cycle
//   pc       out  current fetch address, always word aligned
//   pcPlus4  out  pc + PC_STEP, wrapping modulo 2^XLEN
module fseq_pc_gen
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            loadEn,
  input  logic [XLEN-1:0] loadPc,
  input  logic            incEn,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4
);

  // Masking rather than slicing keeps every input bit in use and makes the
  // alignment independent of XLEN.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pcReg;

  // Natural width overflow gives the modulo-2^XLEN wrap at the top of memory.
  assign pcPlus4 = pcReg + XLEN'(PC_STEP);
  assign pc      = pcReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcReg <= RESET_PC & ALIGN_MASK;
    end else if (loadEn) begin
      pcReg <= loadPc & ALIGN_MASK;
    end else if (incEn) begin
      pcReg <= pcPlus4;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - RV32 instruction-fetch sequencer with redirect and stall handling
//
// Ports:
//   clk             in   clock
//   rst             in   asynchronous reset, active-low
//   redirect_valid  in   taken branch/jump from Execute
//   redirect_pc     in   redirect target address
//   stall_d         in   Decode cannot accept an instruction this cycle
//   imem_req_valid  out  request to instruction memory
//   imem_req_ready  in   memory accepts the request
//   imem_req_addr   out  fetch address (word aligned)
//   imem_rsp_valid  in   response data valid
//   imem_rsp_data   in   instruction word
//   if_valid        out  if_instr/if_pc/if_pc_plus4 are meaningful
//   if_instr        out  fetched instruction
//   if_pc           out  address of if_instr
//   if_pc_plus4     out  if_pc + 4
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4
);

  fseq_state_t     state;
  logic            kill;
  logic            ifValid;
  logic [XLEN-1:0] ifInstr;
  logic [XLEN-1:0] ifPc;
  logic [XLEN-1:0] ifPcPlus4;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pcPlus4;
  logic            takeRsp;

  // A response is kept only when it belongs to the current path: we are
  // waiting for it, it was not marked wrong-path, and no redirect is
  // overriding it in the same cycle.
  assign takeRsp = (state == WAIT) && imem_rsp_valid && !kill && !redirect_valid;

  fseq_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk     (clk),
    .rst     (rst),
    .loadEn  (redirect_valid),
    .loadPc  (redirect_pc),
    .incEn   (takeRsp),
    .pc      (pc),
    .pcPlus4 (pcPlus4)
  );

  // Request outputs are decoded straight from registered state and pc, so
  // the request is visible in the first REQ cycle and follows a redirect
  // on the very next cycle while the memory keeps ready low.
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;

  assign if_valid    = ifValid;
  assign if_instr    = ifInstr;
  assign if_pc       = ifPc;
  assign if_pc_plus4 = ifPcPlus4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BOOT;
      kill      <= 1'b0;
      ifValid   <= 1'b0;
      ifInstr   <= '0;
      ifPc      <= '0;
      ifPcPlus4 <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= REQ;
        end
        REQ: begin
          // A redirect accepted together with the request makes the
          // in-flight fetch wrong-path; kill marks its response for drop.
          if (imem_req_ready) begin
            state <= WAIT;
            kill  <= redirect_valid;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            kill  <= 1'b0;
            state <= (takeRsp && stall_d) ? HOLD : REQ;
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid || !stall_d) begin
            state <= REQ;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase

      // IF/ID register: a redirect flushes, a kept response loads, and an
      // instruction Decode consumed without a replacement is retired.
      // With stall_d high and nothing else happening everything holds.
      if (redirect_valid) begin
        ifValid <= 1'b0;
      end else if (takeRsp) begin
        ifValid   <= 1'b1;
        ifInstr   <= imem_rsp_data;
        ifPc      <= pc;
        ifPcPlus4 <= pcPlus4;
      end else if (!stall_d) begin
        ifValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int vecCount  = 0;
  int missCount = 0;

  // Memory model state (driven only from the stimulus process).
  logic        memReady;
  int          memLat;
  logic        strayRsp;
  logic        pendValid;
  logic [31:0] pendAddr;
  int          pendCnt;
  int          acceptCount;
  logic [31:0] lastAcceptAddr;
  int          acceptBase;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_d        (stall_d),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: present the memory response, clock, then update the
  // memory model. Called #1 after a rising edge; returns #1 after the next.
  task automatic cycle();
    logic        acc;
    logic        fired;
    logic [31:0] addr;
    fired          = pendValid && (pendCnt == 0);
    imem_rsp_valid = fired || strayRsp;
    imem_rsp_data  = strayRsp ? 32'hDEAD_BEEF : pendAddr + 32'h13;
    imem_req_ready = memReady;
    #1;
    acc  = imem_req_valid && imem_req_ready;
    addr = imem_req_addr;
    @(posedge clk);
    #1;
    if (fired) pendValid = 1'b0;
    else if (pendValid && pendCnt > 0) pendCnt--;
    if (acc) begin
      pendValid      = 1'b1;
      pendAddr       = addr;
      pendCnt        = memLat - 1;
      acceptCount++;
      lastAcceptAddr = addr;
    end
    imem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall_d        = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    memReady       = 1'b1;
    memLat         = 1;
    strayRsp       = 1'b0;
    pendValid      = 1'b0;
    pendAddr       = '0;
    pendCnt        = 0;
    acceptCount    = 0;
    lastAcceptAddr = '0;
    acceptBase     = 0;

    @(posedge clk); #1;
    repeat (2) cycle();
    checkVec("rst_if_valid", {31'd0, if_valid}, 32'd0);
    checkVec("rst_if_instr", if_instr, 32'd0);
    checkVec("rst_if_pc", if_pc, 32'd0);
    checkVec("rst_if_pc4", if_pc_plus4, 32'd0);
    checkVec("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // Sequential fetch, always-ready memory, 1-cycle response.
    rst = 1'b1;
    cycle();                                   // BOOT -> REQ
    checkVec("seq_req0_valid", {31'd0, imem_req_valid}, 32'd1);
    checkVec("seq_req0_addr", imem_req_addr, 32'h0);
    cycle();                                   // accepted, WAIT
    checkVec("seq_wait_req", {31'd0, imem_req_valid}, 32'd0);
    cycle();                                   // response for 0x0
    checkVec("seq_if_valid0", {31'd0, if_valid}, 32'd1);
    checkVec("seq_if_pc0", if_pc, 32'h0);
    checkVec("seq_if_pc4_0", if_pc_plus4, 32'h4);
    checkVec("seq_if_instr0", if_instr, 32'h13);
    checkVec("seq_req1_addr", imem_req_addr, 32'h4);
    cycle();                                   // 0x4 accepted, 0x0 consumed
    checkVec("seq_consumed", {31'd0, if_valid}, 32'd0);

    // Stall: response for 0x4 lands with stall_d high, then held 3 cycles.
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkVec($sformatf("hold_if_valid%0d", i), {31'd0, if_valid}, 32'd1);
      checkVec($sformatf("hold_if_pc%0d", i), if_pc, 32'h4);
      checkVec($sformatf("hold_no_req%0d", i), {31'd0, imem_req_valid}, 32'd0);
    end
    checkVec("hold_if_pc4", if_pc_plus4, 32'h8);
    checkVec("hold_if_instr", if_instr, 32'h17);
    stall_d = 1'b0;
    cycle();
    checkVec("unstall_if_valid", {31'd0, if_valid}, 32'd0);
    checkVec("unstall_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkVec("unstall_req_addr", imem_req_addr, 32'h8);

    // Redirect while waiting on 0x8; its response arrives two cycles later.
    memLat = 3;
    cycle();                                   // 0x8 accepted
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    checkVec("rdw_if_valid_a", {31'd0, if_valid}, 32'd0);
    checkVec("rdw_req_valid_a", {31'd0, imem_req_valid}, 32'd0);
    cycle();                                   // stale response dropped
    checkVec("rdw_if_valid_b", {31'd0, if_valid}, 32'd0);
    checkVec("rdw_req_valid_b", {31'd0, imem_req_valid}, 32'd1);
    checkVec("rdw_req_addr", imem_req_addr, 32'h100);

    // Redirect to an unaligned target in the same cycle as the response.
    memLat = 1;
    cycle();                                   // 0x100 accepted
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    cycle();
    redirect_valid = 1'b0;
    checkVec("rsp_rd_if_valid", {31'd0, if_valid}, 32'd0);
    checkVec("rsp_rd_req_addr", imem_req_addr, 32'h200);
    cycle();
    cycle();
    checkVec("after_rd_if_valid", {31'd0, if_valid}, 32'd1);
    checkVec("after_rd_if_pc", if_pc, 32'h200);
    checkVec("after_rd_if_instr", if_instr, 32'h213);

    // Ready held low 4 cycles with a redirect on the second one.
    memReady   = 1'b0;
    acceptBase = acceptCount;
    cycle();
    checkVec("nrdy_addr_a", imem_req_addr, 32'h204);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    checkVec("nrdy_addr_b", imem_req_addr, 32'h40);
    checkVec("nrdy_req_valid", {31'd0, imem_req_valid}, 32'd1);
    cycle();
    cycle();
    checkVec("nrdy_addr_c", imem_req_addr, 32'h40);
    memReady = 1'b1;
    cycle();
    checkVec("nrdy_accept_cnt", 32'(acceptCount - acceptBase), 32'd1);
    checkVec("nrdy_accept_addr", lastAcceptAddr, 32'h40);
    cycle();
    checkVec("nrdy_if_pc", if_pc, 32'h40);
    checkVec("nrdy_if_instr", if_instr, 32'h53);

    // Redirect together with an accepted request: response must be killed.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    checkVec("reqkill_if_valid_a", {31'd0, if_valid}, 32'd0);
    checkVec("reqkill_wait", {31'd0, imem_req_valid}, 32'd0);
    cycle();
    checkVec("reqkill_if_valid_b", {31'd0, if_valid}, 32'd0);
    checkVec("reqkill_req_addr", imem_req_addr, 32'hFFFF_FFFC);

    // Top-of-memory fetch wraps pc+4 to zero.
    cycle();
    cycle();
    checkVec("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    checkVec("wrap_if_pc4", if_pc_plus4, 32'h0);
    checkVec("wrap_if_instr", if_instr, 32'h0000_000F);
    checkVec("wrap_req_addr", imem_req_addr, 32'h0);

    // Asynchronous reset in WAIT with a response still in flight.
    memLat = 2;
    cycle();                                   // 0x0 accepted, WAIT
    #2 rst = 1'b0;
    #1;
    checkVec("arst_if_valid", {31'd0, if_valid}, 32'd0);
    checkVec("arst_if_instr", if_instr, 32'd0);
    checkVec("arst_if_pc", if_pc, 32'd0);
    checkVec("arst_if_pc4", if_pc_plus4, 32'd0);
    checkVec("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    cycle();
    rst = 1'b1;
    cycle();                                   // BOOT, late response ignored
    checkVec("boot_stray_if_valid", {31'd0, if_valid}, 32'd0);
    checkVec("boot_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkVec("boot_req_addr", imem_req_addr, 32'h0);
    memReady = 1'b0; strayRsp = 1'b1;
    cycle();                                   // stray response in REQ
    strayRsp = 1'b0;
    checkVec("req_stray_if_valid", {31'd0, if_valid}, 32'd0);
    checkVec("req_stray_addr", imem_req_addr, 32'h0);
    memReady = 1'b1; memLat = 1;
    cycle();
    cycle();
    checkVec("post_rst_if_valid", {31'd0, if_valid}, 32'd1);
    checkVec("post_rst_if_pc", if_pc, 32'h0);
    checkVec("post_rst_if_instr", if_instr, 32'h13);
    checkVec("post_rst_req_addr", imem_req_addr, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the instruction-fetch stage of the pipelined RV32 core.
- Generates the PC and issues requests to a variable-latency instruction memory over a valid/ready request and valid response handshake.
- Presents fetched instructions to the IF/ID boundary with valid/stall semantics.
- On branch/jump redirects from Execute, discards wrong-path in-flight responses and fetched instructions.
- One outstanding memory request at a time.

Parameters:
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- redirect_valid  in  1  PCSrcE, taken branch/jump from Execute
- redirect_pc  in  XLEN  PCTargetE
- stall_d  in  1  Decode cannot accept an instruction this cycle
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts the request
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  response data valid (at most one per accepted request)
- imem_rsp_data  in  XLEN  instruction word
- if_valid  out  1  InstrD/PCD/PCPlus4D are meaningful
- if_instr  out  XLEN  InstrD
- if_pc  out  XLEN  PCD
- if_pc_plus4  out  XLEN  PCPlus4D

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BOOT; pc=RESET_PC; kill=0.
  - if_valid=0; if_instr=0; if_pc=0; if_pc_plus4=0; imem_req_valid=0.
- States: BOOT, REQ, WAIT, HOLD.
  - BOOT: one cycle after reset release, then REQ. No request issued in BOOT.
  - REQ:
    - Drive imem_req_valid=1 and imem_req_addr=pc.
    - If ready=1 and no redirect: go to WAIT.
    - If redirect_valid=1: pc<=redirect_pc. If ready was also 1 in the same cycle, set kill=1 and go to WAIT; otherwise stay in REQ.
  - WAIT:
    - imem_req_valid=0.
    - On rsp_valid with kill=0 and no redirect: load if_instr=rsp_data, if_pc=pc, if_pc_plus4=pc+4, if_valid=1; pc<=pc+4. Go to HOLD if stall_d=1, else REQ.
    - On rsp_valid with kill=1: discard the response, clear kill, go to REQ.
    - redirect_valid in WAIT: pc<=redirect_pc and kill<=1. If rsp_valid arrives in the same cycle, discard the response and go to REQ with kill=0.
  - HOLD:
    - Outputs are frozen while stall_d=1.
    - When stall_d=0: if_valid<=0, then go to REQ.
    - redirect_valid in HOLD: if_valid<=0, pc<=redirect_pc, go to REQ.
- Consumption rule: if_valid=1 and stall_d=0 means Decode takes the instruction that cycle. If no new instruction is loaded in that cycle, if_valid<=0.
- Flush rule: redirect_valid=1 forces if_valid=0 on the next cycle, regardless of state or stall_d. Redirect has priority over stall_d and over any response arriving in the same cycle.
- Latency:
  - The request is visible in the first REQ cycle.
  - if_valid rises the cycle after rsp_valid.
  - Best-case throughput is 1 instruction per 2 cycles (REQ, then 1-cycle WAIT).
- Arithmetic rules:
  - redirect_pc[1:0] is forced to 2'b00.
  - pc+4 is computed modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
  - imem_req_addr[1:0] is always 00.
- Stray response (rsp_valid in REQ, HOLD or BOOT): ignored, with no state change.
- Reset mid-operation: immediate return to reset values. Any pending memory response after reset release is ignored until a new request is issued.

Decomposition:
- fetch_pkg holds:
  - fseq_state_t enum {BOOT, REQ, WAIT, HOLD}
  - constant DEFAULT_RESET_PC
  - constant PC_STEP=4
- One natural sub-module: fseq_pc_gen. It contains the pc register, +4 increment, redirect mux and alignment forcing, and exposes pc and the load/increment controls.
- The FSM, kill flag and IF/ID output register stay in fetch_sequencer.

Test Plan:
- Reset release, memory always ready with 1-cycle response returning 0x00000013 → req addr 0x0, 0x4, 0x8 on successive REQ cycles; if_valid pulses with if_pc=0x0/if_pc_plus4=0x4, then 0x4/0x8.
- stall_d held high for 3 cycles after if_valid with if_pc=0x4 → outputs frozen and no new request; request for 0x8 issued the cycle after stall_d drops.
- Redirect to 0x100 while in WAIT for 0x8, response arriving 2 cycles later → response discarded, if_valid stays 0, next req addr=0x100.
- Redirect to 0x203 in the same cycle as rsp_valid → response dropped; next req addr=0x200.
- imem_req_ready held low 4 cycles, redirect to 0x40 on cycle 2 → imem_req_addr changes to 0x40; exactly one request accepted, at 0x40.
- pc=0xFFFF_FFFC fetch completes → if_pc_plus4=0x0 and next req addr=0x0. Assert rst mid-WAIT → all outputs return to 0 asynchronously; the first request after release is at RESET_PC.
